// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential synchronous memory reads,
// and buffers {pc, instr} pairs in a small FIFO that feeds decode over valid/ready.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 4,
  parameter int unsigned         DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned       PTR_W      = $clog2(DEPTH);
  localparam int unsigned       CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

  logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflightPc_q, inflightPc_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  fifoPc_q    [DEPTH];
  logic [INSTR_W-1:0] fifoInstr_q [DEPTH];

  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   credit;

  assign instr_valid = (count_q != '0) & !redirect_valid;
  assign instr       = fifoInstr_q[rdPtr_q];
  assign instr_pc    = fifoPc_q[rdPtr_q];
  assign imem_addr   = fetchPc_q;

  // Credit check counts the in-flight read as occupying a slot, so a capture always fits.
  always_comb begin
    pop      = instr_valid & instr_ready;
    push     = inflight_q & !redirect_valid;
    credit   = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    imem_req = rst_n & !redirect_valid & (credit < CNT_W'(DEPTH));
  end

  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflight_d   = imem_req;
    inflightPc_d = inflightPc_q;
    rdPtr_d      = rdPtr_q + PTR_W'(pop);
    wrPtr_d      = wrPtr_q + PTR_W'(push);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    if (imem_req) begin
      fetchPc_d    = fetchPc_q + STEP;
      inflightPc_d = fetchPc_q;
    end
    if (redirect_valid) begin
      fetchPc_d = redirect_pc & ALIGN_MASK;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q    <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
      count_q      <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoPc_q[wrPtr_q]    <= inflightPc_q;
      fifoInstr_q[wrPtr_q] <= imem_rdata;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count_q == CNT_W'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table plus reset, wrap-around and randomized scoreboard sequences
// for fetch_unit across three parameterisations.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance: DEPTH=2, RESET_PC=0x100
  logic        rstA = 1'b0, reqA, validA, readyA = 1'b0, redirA = 1'b0;
  logic [31:0] addrA, rdataA = '0, instrA, pcA, redirPcA = '0;

  // Wrap-around instance: 8-bit addresses
  logic        rstW = 1'b0, reqW, validW, readyW = 1'b1, redirW = 1'b0;
  logic [7:0]  addrW, pcW, redirPcW = '0;
  logic [31:0] rdataW = '0, instrW;

  // Randomized instance: DEPTH=4
  logic        rstR = 1'b0, reqR, validR, readyR = 1'b0, redirR = 1'b0;
  logic [31:0] addrR, rdataR = '0, instrR, pcR, redirPcR = '0;

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100), .PC_STEP(4), .DEPTH(2)) dutA (
    .clk(clk), .rst_n(rstA), .imem_req(reqA), .imem_addr(addrA), .imem_rdata(rdataA),
    .instr_valid(validA), .instr(instrA), .instr_pc(pcA), .instr_ready(readyA),
    .redirect_valid(redirA), .redirect_pc(redirPcA));

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8), .PC_STEP(4), .DEPTH(2)) dutW (
    .clk(clk), .rst_n(rstW), .imem_req(reqW), .imem_addr(addrW), .imem_rdata(rdataW),
    .instr_valid(validW), .instr(instrW), .instr_pc(pcW), .instr_ready(readyW),
    .redirect_valid(redirW), .redirect_pc(redirPcW));

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4), .DEPTH(4)) dutR (
    .clk(clk), .rst_n(rstR), .imem_req(reqR), .imem_addr(addrR), .imem_rdata(rdataR),
    .instr_valid(validR), .instr(instrR), .instr_pc(pcR), .instr_ready(readyR),
    .redirect_valid(redirR), .redirect_pc(redirPcR));

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Synchronous memories: data only defined one cycle after a request.
  always @(posedge clk) begin
    rdataA <= reqA ? memData(addrA) : 32'hBAD0_BAD0;
    rdataW <= reqW ? memData({24'h0, addrW}) : 32'hBAD0_BAD0;
    rdataR <= reqR ? memData(addrR) : 32'hBAD0_BAD0;
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] redirPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr,
                              input logic val, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.redirPc = rpc;
    v.expReq = req; v.expAddr = addr; v.expValid = val; v.expPc = pc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    readyA   = v.rdy;
    redirA   = v.redir;
    redirPcA = v.redirPc;
  endtask

  task automatic checkVector(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    checkOutput({tag, ".req"}, 64'(reqA), 64'(vecs[i].expReq));
    checkOutput({tag, ".valid"}, 64'(validA), 64'(vecs[i].expValid));
    if (vecs[i].expReq) checkOutput({tag, ".addr"}, 64'(addrA), 64'(vecs[i].expAddr));
    if (vecs[i].expValid) begin
      checkOutput({tag, ".pc"}, 64'(pcA), 64'(vecs[i].expPc));
      checkOutput({tag, ".instr"}, 64'(instrA), 64'(memData(vecs[i].expPc)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] expPc;
    logic        prevHold;
    logic [31:0] heldPc, heldInstr;
    int          pops;
    logic [7:0]  wrapPcs [4];

    // Cycle-by-cycle table for dutA: startup, stall/release, redirect, held redirect.
    vecs[0]  = mk(1, 0, 32'h0,    1, 32'h100,  0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0,    1, 32'h104,  0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,    0, 32'h0,    1, 32'h100);
    vecs[3]  = mk(0, 0, 32'h0,    0, 32'h0,    1, 32'h100);
    vecs[4]  = mk(0, 0, 32'h0,    0, 32'h0,    1, 32'h100);
    vecs[5]  = mk(1, 0, 32'h0,    1, 32'h108,  1, 32'h100);
    vecs[6]  = mk(1, 0, 32'h0,    1, 32'h10C,  1, 32'h104);
    vecs[7]  = mk(1, 0, 32'h0,    1, 32'h110,  1, 32'h108);
    vecs[8]  = mk(0, 1, 32'h2003, 0, 32'h0,    0, 32'h0);
    vecs[9]  = mk(1, 0, 32'h0,    1, 32'h2000, 0, 32'h0);
    vecs[10] = mk(1, 0, 32'h0,    1, 32'h2004, 0, 32'h0);
    vecs[11] = mk(1, 0, 32'h0,    1, 32'h2008, 1, 32'h2000);
    vecs[12] = mk(1, 0, 32'h0,    1, 32'h200C, 1, 32'h2004);
    vecs[13] = mk(1, 1, 32'h3000, 0, 32'h0,    0, 32'h0);
    vecs[14] = mk(1, 1, 32'h4004, 0, 32'h0,    0, 32'h0);
    vecs[15] = mk(1, 0, 32'h0,    1, 32'h4004, 0, 32'h0);
    vecs[16] = mk(1, 0, 32'h0,    1, 32'h4008, 0, 32'h0);
    vecs[17] = mk(1, 0, 32'h0,    1, 32'h400C, 1, 32'h4004);
    vecs[18] = mk(1, 0, 32'h0,    1, 32'h4010, 1, 32'h4008);

    readyA = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset.req", 64'(reqA), 64'(0));
    checkOutput("reset.valid", 64'(validA), 64'(0));
    rstA = 1'b1;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges while the unit is streaming.
    applyStimulus(mk(1, 0, 32'h0, 0, 32'h0, 0, 32'h0));
    #1;
    checkOutput("preRst.valid", 64'(validA), 64'(1));
    @(posedge clk);
    #2;
    rstA = 1'b0;
    #1;
    checkOutput("asyncRst.valid", 64'(validA), 64'(0));
    checkOutput("asyncRst.req", 64'(reqA), 64'(0));
    repeat (2) @(negedge clk);
    rstA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVector(i);
      @(negedge clk);
    end

    // Address wrap-around on an 8-bit PC.
    wrapPcs[0] = 8'hF8; wrapPcs[1] = 8'hFC; wrapPcs[2] = 8'h00; wrapPcs[3] = 8'h04;
    rstW = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 2) begin
        checkOutput($sformatf("wrap.c%0d.valid", c), 64'(validW), 64'(0));
      end else begin
        checkOutput($sformatf("wrap.c%0d.valid", c), 64'(validW), 64'(1));
        checkOutput($sformatf("wrap.c%0d.pc", c), 64'(pcW), 64'(wrapPcs[c-2]));
        checkOutput($sformatf("wrap.c%0d.instr", c), 64'(instrW),
                    64'(memData({24'h0, wrapPcs[c-2]})));
      end
      @(negedge clk);
    end

    // Random ready/redirect traffic on the DEPTH=4 instance with a PC-stream scoreboard.
    rstR     = 1'b1;
    expPc    = 32'h0;
    prevHold = 1'b0;
    heldPc   = '0;
    heldInstr = '0;
    pops     = 0;
    for (int c = 0; c < 3000; c++) begin
      readyR   = 1'($urandom_range(0, 1));
      redirR   = ($urandom_range(0, 39) == 0);
      redirPcR = $urandom & 32'h0000_FFFF;
      #1;
      if (redirR) begin
        checkOutput("rand.redirValid", 64'(validR), 64'(0));
        checkOutput("rand.redirReq", 64'(reqR), 64'(0));
        expPc    = redirPcR & ~32'h3;
        prevHold = 1'b0;
      end else begin
        if (prevHold) begin
          checkOutput("rand.holdValid", 64'(validR), 64'(1));
          checkOutput("rand.holdPc", 64'(pcR), 64'(heldPc));
          checkOutput("rand.holdInstr", 64'(instrR), 64'(heldInstr));
        end
        if (validR && readyR) begin
          checkOutput("rand.pc", 64'(pcR), 64'(expPc));
          checkOutput("rand.instr", 64'(instrR), 64'(memData(expPc)));
          expPc = expPc + 32'd4;
          pops++;
        end
        prevHold  = validR & !readyR;
        heldPc    = pcR;
        heldInstr = instrR;
      end
      @(negedge clk);
    end
    checkOutput("rand.enoughPops", 64'(pops > 500), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
